// File: rtl/inv_reg_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready handshake.
// A masked inversion is applied once at capture; later stages are plain registers.
module inv_reg_pipe #(
    parameter int unsigned       WIDTH     = 8,
    parameter int unsigned       DEPTH     = 3,
    parameter logic [WIDTH-1:0]  INV_MASK  = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             d_in,
    input  logic                         inv_en,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             d_out,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [WIDTH-1:0] data [DEPTH];
    logic             accept;
    logic             pop;
    logic             hole;

    // Stage k can load when it, or any stage downstream of it, frees up this cycle.
    always_comb begin
        rdy  = '0;
        hole = out_ready;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            hole   = hole | ~v[k];
            rdy[k] = hole;
        end
        in_ready = rdy[0] & ~flush & rst;
        accept   = in_valid & in_ready;
        pop      = v[DEPTH-1] & out_ready;
    end

    assign out_valid = v[DEPTH-1];
    assign d_out     = data[DEPTH-1];

    // Stage valids, data and occupancy; flush drops valids but keeps data.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            v     <= '0;
            count <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                data[k] <= RESET_VAL;
            end
        end else if (flush) begin
            v     <= '0;
            count <= '0;
        end else begin
            if (rdy[0]) begin
                v[0] <= accept;
                if (accept) begin
                    data[0] <= d_in ^ (INV_MASK & {WIDTH{inv_en}});
                end
            end
            for (int k = 1; k < int'(DEPTH); k++) begin
                if (rdy[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        data[k] <= data[k-1];
                    end
                end
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Occupancy must always match the number of valid stages.
    assert property (@(posedge clock) disable iff (!rst) count <= CW'(DEPTH));
    assert property (@(posedge clock) disable iff (!rst) count == CW'($countones(v)));

endmodule

// File: tb/tb_inv_reg_pipe.sv
// Directed bench for inv_reg_pipe: default config, a partial-mask config and DEPTH=1.
module tb_inv_reg_pipe;

    logic clock = 1'b0;
    logic rst   = 1'b0;

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // u0: WIDTH=8, DEPTH=3, INV_MASK=FF
    logic       a_in_valid = 1'b0, a_inv_en = 1'b0, a_flush = 1'b0, a_out_ready = 1'b0;
    logic [7:0] a_d_in = 8'h00;
    logic       a_in_ready, a_out_valid;
    logic [7:0] a_d_out;
    logic [1:0] a_count;

    // u1: WIDTH=8, DEPTH=3, INV_MASK=0F
    logic       b_in_valid = 1'b0, b_inv_en = 1'b0, b_flush = 1'b0, b_out_ready = 1'b0;
    logic [7:0] b_d_in = 8'h00;
    logic       b_in_ready, b_out_valid;
    logic [7:0] b_d_out;
    logic [1:0] b_count;

    // u2: WIDTH=8, DEPTH=1, INV_MASK=FF
    logic       c_in_valid = 1'b0, c_inv_en = 1'b0, c_flush = 1'b0, c_out_ready = 1'b0;
    logic [7:0] c_d_in = 8'h00;
    logic       c_in_ready, c_out_valid;
    logic [7:0] c_d_out;
    logic [0:0] c_count;

    inv_reg_pipe #(.WIDTH(8), .DEPTH(3), .INV_MASK(8'hFF), .RESET_VAL(8'h00)) u0 (
        .clock(clock), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .d_in(a_d_in), .inv_en(a_inv_en), .flush(a_flush), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .d_out(a_d_out), .count(a_count)
    );

    inv_reg_pipe #(.WIDTH(8), .DEPTH(3), .INV_MASK(8'h0F), .RESET_VAL(8'h00)) u1 (
        .clock(clock), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .d_in(b_d_in), .inv_en(b_inv_en), .flush(b_flush), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .d_out(b_d_out), .count(b_count)
    );

    inv_reg_pipe #(.WIDTH(8), .DEPTH(1), .INV_MASK(8'hFF), .RESET_VAL(8'h00)) u2 (
        .clock(clock), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .d_in(c_d_in), .inv_en(c_inv_en), .flush(c_flush), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .d_out(c_d_out), .count(c_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset held with a beat offered
        a_in_valid = 1'b1;
        a_d_in     = 8'hAA;
        repeat (2) tick();
        check("rst_out_valid", 32'(a_out_valid), 32'h0);
        check("rst_d_out",     32'(a_d_out),     32'h00);
        check("rst_count",     32'(a_count),     32'h0);
        check("rst_in_ready",  32'(a_in_ready),  32'h0);
        a_in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rel_in_ready",  32'(a_in_ready),  32'h1);

        // Streaming with full inversion
        a_inv_en = 1'b1; a_out_ready = 1'b1; a_in_valid = 1'b1;
        a_d_in = 8'h00; tick();
        check("str_ov_e1",  32'(a_out_valid), 32'h0);
        a_d_in = 8'h0F; tick();
        check("str_ov_e2",  32'(a_out_valid), 32'h0);
        a_d_in = 8'hA5; tick();
        check("str_ov_e3",  32'(a_out_valid), 32'h1);
        check("str_dout0",  32'(a_d_out),     32'hFF);
        check("str_cnt3",   32'(a_count),     32'h3);
        a_in_valid = 1'b0; tick();
        check("str_dout1",  32'(a_d_out),     32'hF0);
        check("str_cnt2",   32'(a_count),     32'h2);
        tick();
        check("str_dout2",  32'(a_d_out),     32'h5A);
        check("str_ov_b2",  32'(a_out_valid), 32'h1);
        tick();
        check("str_empty",  32'(a_out_valid), 32'h0);
        check("str_hold",   32'(a_d_out),     32'h5A);
        check("str_cnt0",   32'(a_count),     32'h0);

        // Partial mask, runtime inversion toggle
        b_out_ready = 1'b1; b_in_valid = 1'b1; b_d_in = 8'h3C; b_inv_en = 1'b0; tick();
        b_inv_en = 1'b1; tick();
        b_in_valid = 1'b0; b_inv_en = 1'b0; tick();
        check("mask_ov0",   32'(b_out_valid), 32'h1);
        check("mask_b0",    32'(b_d_out),     32'h3C);
        tick();
        check("mask_b1",    32'(b_d_out),     32'h33);
        tick();
        check("mask_empty", 32'(b_out_valid), 32'h0);

        // Backpressure: fill, stall, then drain without gaps
        a_out_ready = 1'b0; a_inv_en = 1'b1; a_in_valid = 1'b1;
        a_d_in = 8'h01; tick();
        a_d_in = 8'h02; tick();
        a_d_in = 8'h03; tick();
        a_d_in = 8'h04; #1;
        check("bp_in_ready", 32'(a_in_ready), 32'h0);
        check("bp_cnt_full", 32'(a_count),    32'h3);
        tick();
        check("bp_hold_cnt", 32'(a_count),    32'h3);
        check("bp_hold_out", 32'(a_d_out),    32'hFE);
        check("bp_hold_ov",  32'(a_out_valid), 32'h1);
        a_out_ready = 1'b1; #1;
        check("bp_full_rdy", 32'(a_in_ready), 32'h1);
        tick();
        check("bp_dout1",    32'(a_d_out),    32'hFD);
        check("bp_cnt_same", 32'(a_count),    32'h3);
        a_in_valid = 1'b0; tick();
        check("bp_dout2",    32'(a_d_out),    32'hFC);
        check("bp_ov2",      32'(a_out_valid), 32'h1);
        tick();
        check("bp_dout3",    32'(a_d_out),    32'hFB);
        check("bp_ov3",      32'(a_out_valid), 32'h1);
        tick();
        check("bp_drained",  32'(a_out_valid), 32'h0);
        check("bp_cnt0",     32'(a_count),    32'h0);

        // Flush with a concurrent beat offered
        a_d_in = 8'h10; a_in_valid = 1'b1; tick();
        a_d_in = 8'h20; tick();
        check("fl_cnt2",     32'(a_count),    32'h2);
        a_flush = 1'b1; a_d_in = 8'h77; #1;
        check("fl_in_ready", 32'(a_in_ready), 32'h0);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        check("fl_cnt0",     32'(a_count),    32'h0);
        check("fl_data_kept", 32'(a_d_out),   32'hFB);
        for (int i = 0; i < 4; i++) begin
            check("fl_no_out", 32'(a_out_valid), 32'h0);
            tick();
        end

        // Async reset between edges, then a normal beat
        a_out_ready = 1'b0; a_inv_en = 1'b0; a_in_valid = 1'b1;
        a_d_in = 8'h31; tick();
        a_d_in = 8'h32; tick();
        a_in_valid = 1'b0;
        check("ar_cnt2",     32'(a_count),    32'h2);
        #2 rst = 1'b0;
        #1;
        check("ar_ov",       32'(a_out_valid), 32'h0);
        check("ar_cnt",      32'(a_count),    32'h0);
        check("ar_dout",     32'(a_d_out),    32'h00);
        #2 rst = 1'b1;
        tick();
        a_inv_en = 1'b1; a_out_ready = 1'b1; a_in_valid = 1'b1; a_d_in = 8'h5C; tick();
        a_in_valid = 1'b0; tick(); tick();
        check("ar_after_ov",  32'(a_out_valid), 32'h1);
        check("ar_after_out", 32'(a_d_out),     32'hA3);
        check("ar_after_cnt", 32'(a_count),     32'h1);

        // DEPTH=1 single register
        c_out_ready = 1'b0; c_inv_en = 1'b1; c_in_valid = 1'b1; c_d_in = 8'h12; #1;
        check("d1_rdy_empty", 32'(c_in_ready), 32'h1);
        tick();
        check("d1_ov",       32'(c_out_valid), 32'h1);
        check("d1_dout0",    32'(c_d_out),     32'hED);
        check("d1_rdy_full", 32'(c_in_ready),  32'h0);
        c_out_ready = 1'b1; c_d_in = 8'h34; #1;
        check("d1_rdy_pop",  32'(c_in_ready),  32'h1);
        tick();
        check("d1_dout1",    32'(c_d_out),     32'hCB);
        check("d1_cnt1",     32'(c_count),     32'h1);
        c_in_valid = 1'b0; tick();
        check("d1_empty",    32'(c_out_valid), 32'h0);
        check("d1_cnt0",     32'(c_count),     32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
